// File: rtl/synth_mac_pkg.sv
// Shared constants for the polyphase-synthesis MAC scheduler: register map,
// FSM state encoding and STATUS bit positions.
package synth_mac_pkg;
  localparam logic [4:0] REG_VADDR  = 5'h00;
  localparam logic [4:0] REG_IDX    = 5'h04;
  localparam logic [4:0] REG_CTRL   = 5'h08;
  localparam logic [4:0] REG_STATUS = 5'h0C;
  localparam logic [4:0] REG_RESULT = 5'h10;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_PUSH  = 2'd3;

  localparam int ST_BUSY      = 0;
  localparam int ST_CNT_LO    = 8;
  localparam int ST_START_ERR = 16;
  localparam int ST_UNDER_ERR = 17;
  localparam int ST_OVER_ERR  = 18;
endpackage

// File: rtl/synth_mac_sched_fifo.sv
// Result FIFO: 32-bit synchronous FIFO with occupancy count; head is
// visible combinationally so a pop returns the old head.
module synth_result_fifo #(
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [31:0]   i_wdata,
  input  logic          i_pop,
  output logic [31:0]   o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // a full FIFO can still take a push when the head leaves in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/synth_mac_sched.sv
// MMIO-driven scheduler for the synthesis windowed MAC: issues TAPS reads per
// output, accumulates coef*sample through a 2-stage pipe, queues results.
module synth_mac_sched
  import synth_mac_pkg::*;
#(
  parameter int TAPS       = 8,
  parameter int TAP_STRIDE = 512,
  parameter int IDX_STRIDE = 64,
  parameter int OUT_STRIDE = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_reg_valid,
  output logic        o_reg_ready,
  input  logic        i_reg_write,
  input  logic [4:0]  i_reg_addr,
  input  logic [31:0] i_reg_wdata,
  output logic        o_reg_rsp_valid,
  output logic [31:0] o_reg_rsp_data,
  output logic        o_mem_cmd_valid,
  input  logic        i_mem_cmd_ready,
  output logic [31:0] o_mem_cmd_addr,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic [8:0]  o_coef_idx,
  input  logic [17:0] i_coef,
  output logic        o_busy
);
  localparam int IW = $clog2(TAPS) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             r_state;
  logic [31:0]        r_vaddr, r_cur_addr, r_accu, r_rsp_data;
  logic [8:0]         r_idx, r_cur_idx;
  logic [4:0]         r_cnt;
  logic [5:0]         r_remaining;
  logic [IW-1:0]      r_issued, r_rsp_cnt;
  logic               r_s1_vld, r_rsp_valid;
  logic signed [17:0] r_coef;
  logic signed [31:0] r_samp;
  logic               r_start_err, r_under_err, r_over_err;

  logic               w_wr, w_rd, w_start, w_pop_req, w_fifo_pop, w_push;
  logic               w_cmd_fire, w_rsp_take, w_rsp_drop;
  logic               w_fifo_full, w_fifo_empty;
  logic [CW-1:0]      w_fifo_count;
  logic [31:0]        w_fifo_rdata, w_status, w_rdata;
  logic signed [31:0] w_coef_sx, w_prod;

  assign o_reg_ready     = 1'b1;
  assign o_reg_rsp_valid = r_rsp_valid;
  assign o_reg_rsp_data  = r_rsp_data;
  assign o_busy          = (r_state != S_IDLE);
  assign o_mem_cmd_valid = (r_state == S_ISSUE);
  assign o_mem_cmd_addr  = r_cur_addr + 32'(r_issued) * 32'(TAP_STRIDE);
  assign o_coef_idx      = r_cur_idx + 9'(32'(r_rsp_cnt) * 32'(IDX_STRIDE));

  assign w_wr       = i_reg_valid && i_reg_write;
  assign w_rd       = i_reg_valid && !i_reg_write;
  assign w_start    = w_wr && (i_reg_addr == REG_CTRL) && i_reg_wdata[0];
  assign w_pop_req  = w_rd && (i_reg_addr == REG_RESULT);
  assign w_fifo_pop = w_pop_req && !w_fifo_empty;
  assign w_push     = (r_state == S_PUSH) && !w_fifo_full;
  assign w_cmd_fire = o_mem_cmd_valid && i_mem_cmd_ready;
  // only responses owed to the current output are accepted
  assign w_rsp_take = i_mem_rsp_valid && (r_state == S_ISSUE || r_state == S_DRAIN)
                      && (r_rsp_cnt < IW'(TAPS));
  assign w_rsp_drop = i_mem_rsp_valid && !w_rsp_take;
  assign w_coef_sx  = 32'(r_coef);
  assign w_prod     = w_coef_sx * r_samp;

  synth_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (r_accu),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_status                      = '0;
    w_status[ST_BUSY]             = o_busy;
    w_status[ST_CNT_LO +: 6]      = 6'(w_fifo_count);
    w_status[ST_START_ERR]        = r_start_err;
    w_status[ST_UNDER_ERR]        = r_under_err;
    w_status[ST_OVER_ERR]         = r_over_err;
    case (i_reg_addr)
      REG_VADDR:  w_rdata = r_vaddr;
      REG_IDX:    w_rdata = {23'd0, r_idx};
      REG_CTRL:   w_rdata = {19'd0, r_cnt, 8'd0};
      REG_STATUS: w_rdata = w_status;
      REG_RESULT: w_rdata = w_fifo_empty ? 32'd0 : w_fifo_rdata;
      default:    w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_vaddr     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_start_err <= 1'b0;
      r_under_err <= 1'b0;
      r_over_err  <= 1'b0;
    end else begin
      r_rsp_valid <= i_reg_valid;
      r_rsp_data  <= w_rd ? w_rdata : 32'd0;
      if (w_wr) begin
        case (i_reg_addr)
          REG_VADDR: r_vaddr <= i_reg_wdata;
          REG_IDX:   r_idx   <= i_reg_wdata[8:0];
          REG_CTRL:  r_cnt   <= i_reg_wdata[12:8];
          REG_STATUS: begin
            if (i_reg_wdata[ST_START_ERR]) r_start_err <= 1'b0;
            if (i_reg_wdata[ST_UNDER_ERR]) r_under_err <= 1'b0;
            if (i_reg_wdata[ST_OVER_ERR])  r_over_err  <= 1'b0;
          end
          default: ;
        endcase
      end
      // a new error event outranks a clear in the same cycle
      if (w_start && o_busy)           r_start_err <= 1'b1;
      if (w_pop_req && w_fifo_empty)   r_under_err <= 1'b1;
      if (w_rsp_drop)                  r_over_err  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_cur_idx   <= '0;
      r_remaining <= '0;
      r_issued    <= '0;
      r_rsp_cnt   <= '0;
      r_s1_vld    <= 1'b0;
      r_coef      <= '0;
      r_samp      <= '0;
      r_accu      <= '0;
    end else begin
      r_s1_vld <= w_rsp_take;
      if (w_rsp_take) begin
        r_coef    <= i_coef;
        r_samp    <= i_mem_rsp_data;
        r_rsp_cnt <= r_rsp_cnt + 1'b1;
      end
      if (r_s1_vld) r_accu <= r_accu + w_prod;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_cur_addr  <= r_vaddr;
          r_cur_idx   <= r_idx;
          r_remaining <= 6'(i_reg_wdata[12:8]) + 6'd1;
          r_issued    <= '0;
          r_rsp_cnt   <= '0;
          r_accu      <= '0;
          r_state     <= S_ISSUE;
        end
        S_ISSUE: if (w_cmd_fire) begin
          r_issued <= r_issued + 1'b1;
          if (r_issued == IW'(TAPS - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: if (r_rsp_cnt == IW'(TAPS) && !r_s1_vld) r_state <= S_PUSH;
        S_PUSH: if (w_push) begin
          r_cur_addr  <= r_cur_addr + 32'(OUT_STRIDE);
          r_cur_idx   <= r_cur_idx + 9'd1;
          r_remaining <= r_remaining - 6'd1;
          if (r_remaining == 6'd1) begin
            r_state <= S_IDLE;
          end else begin
            r_issued  <= '0;
            r_rsp_cnt <= '0;
            r_accu    <= '0;
            r_state   <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_synth_mac_sched.sv
// Randomized scoreboard bench for synth_mac_sched: a memory/coefficient model
// checks every tap, a monitor checks every register response.
module tb_synth_mac_sched;
  logic        clk = 1'b0, reset;
  logic        i_reg_valid, i_reg_write, o_reg_ready, o_reg_rsp_valid;
  logic [4:0]  i_reg_addr;
  logic [31:0] i_reg_wdata, o_reg_rsp_data;
  logic        o_mem_cmd_valid, i_mem_cmd_ready, i_mem_rsp_valid, o_busy;
  logic [31:0] o_mem_cmd_addr, i_mem_rsp_data;
  logic [8:0]  o_coef_idx;
  logic [17:0] i_coef;

  localparam logic [4:0] A_VADDR = 5'h00, A_IDX = 5'h04, A_CTRL = 5'h08,
                         A_STAT = 5'h0C, A_RES = 5'h10;

  int checks = 0, failures = 0, cyc = 0, tag_ctr = 0;
  int mem_mode = 0, coef_mode = 0, rdy_pct = 100, lat_min = 1, lat_max = 1;
  int cmd_cnt = 0, last_cmd_cyc = 0;

  typedef struct { logic [31:0] exp; logic [31:0] mask; int tag; } sb_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  sb_t         sb_q[$];
  pend_t       pend_q[$];
  logic [31:0] exp_addr_q[$];
  logic [8:0]  exp_idx_q[$];
  logic [31:0] res_q[$];

  synth_mac_sched dut (
    .clk(clk), .reset(reset),
    .i_reg_valid(i_reg_valid), .o_reg_ready(o_reg_ready), .i_reg_write(i_reg_write),
    .i_reg_addr(i_reg_addr), .i_reg_wdata(i_reg_wdata),
    .o_reg_rsp_valid(o_reg_rsp_valid), .o_reg_rsp_data(o_reg_rsp_data),
    .o_mem_cmd_valid(o_mem_cmd_valid), .i_mem_cmd_ready(i_mem_cmd_ready),
    .o_mem_cmd_addr(o_mem_cmd_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data(i_mem_rsp_data), .o_coef_idx(o_coef_idx), .i_coef(i_coef),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp,
                              logic [31:0] mask = 32'hFFFF_FFFF);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
    end
  endfunction

  function automatic logic [31:0] mem_fn(int mode, logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h85EB_CA6B;
    case (mode)
      0: return 32'd1;
      1: return 32'h7FFF_FFFF;
      default: return h ^ (a >> 9) ^ 32'hA5A5_0000;
    endcase
  endfunction

  function automatic logic [17:0] coef_fn(int mode, logic [8:0] i);
    logic [31:0] h;
    h = 32'(i) * 32'h9E37_79B1;
    case (mode)
      0: return 18'(i);
      1: return 18'h1FFFF;
      default: return h[24:7];
    endcase
  endfunction

  assign i_coef = coef_fn(coef_mode, o_coef_idx);

  // Output o = sum over taps of signed coef * signed sample, wrapped to 32 bits
  function automatic logic [31:0] ref_out(logic [31:0] va, logic [8:0] ix, int o);
    int acc, c, s;
    logic signed [17:0] cs;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      cs  = coef_fn(coef_mode, ix + 9'(o) + 9'(64 * t));
      c   = cs;
      s   = mem_fn(mem_mode, va + 32'(4 * o) + 32'(512 * t));
      acc = acc + c * s;
    end
    return acc;
  endfunction

  // Memory port model: decisions made at negedge for the following posedge
  always @(negedge clk) begin
    int lat;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = mem_fn(mem_mode, pend_q[0].addr);
      if (exp_idx_q.size() > 0 && !reset)
        chk("coef_idx", 32'(o_coef_idx), 32'(exp_idx_q.pop_front()));
      void'(pend_q.pop_front());
    end else begin
      i_mem_rsp_valid = 1'b0;
      i_mem_rsp_data  = 32'd0;
    end
    i_mem_cmd_ready = !reset && ($urandom_range(99) < rdy_pct);
    if (o_mem_cmd_valid && i_mem_cmd_ready) begin
      if (exp_addr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_cmd: got addr %h expected no command", o_mem_cmd_addr);
      end else begin
        chk("cmd_addr", o_mem_cmd_addr, exp_addr_q.pop_front());
      end
      lat = $urandom_range(lat_max, lat_min);
      pend_q.push_back('{o_mem_cmd_addr, cyc + 1 + lat});
      cmd_cnt++;
      last_cmd_cyc = cyc;
    end
  end

  // Register response monitor
  always @(negedge clk) begin
    sb_t e;
    if (o_reg_rsp_valid) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL stray_rsp: got data %h expected no response", o_reg_rsp_data);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("reg_rsp#%0d", e.tag), o_reg_rsp_data, e.exp, e.mask);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_acc(input bit wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] e, input logic [31:0] m);
    tag_ctr++;
    i_reg_valid = 1'b1; i_reg_write = wr; i_reg_addr = a; i_reg_wdata = d;
    sb_q.push_back('{e, m, tag_ctr});
    tick(1);
    i_reg_valid = 1'b0; i_reg_write = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_acc(1'b1, a, d, 32'd0, 32'hFFFF_FFFF);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input logic [31:0] m);
    reg_acc(1'b0, a, 32'd0, e, m);
  endtask

  task automatic start_run(input logic [31:0] va, input logic [8:0] ix, input int cnt);
    wr(A_VADDR, va);
    wr(A_IDX, {23'd0, ix});
    for (int o = 0; o < cnt; o++) begin
      res_q.push_back(ref_out(va, ix, o));
      for (int t = 0; t < 8; t++) begin
        exp_addr_q.push_back(va + 32'(4 * o) + 32'(512 * t));
        exp_idx_q.push_back(ix + 9'(o) + 9'(64 * t));
      end
    end
    wr(A_CTRL, {19'd0, 5'(cnt - 1), 7'd0, 1'b1});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin tick(1); n++; end
    if (o_busy) begin
      checks++; failures++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", budget);
    end
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) rd(A_RES, res_q.pop_front(), 32'hFFFF_FFFF);
  endtask

  initial begin
    int base, n, cnt;
    reset = 1'b1; i_reg_valid = 1'b0; i_reg_write = 1'b0;
    i_reg_addr = '0; i_reg_wdata = '0;
    tick(3);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cmd_valid", 32'(o_mem_cmd_valid), 32'd0);
    chk("rst_rsp_valid", 32'(o_reg_rsp_valid), 32'd0);
    chk("rst_rsp_data", o_reg_rsp_data, 32'd0);
    chk("rst_coef_idx", 32'(o_coef_idx), 32'd0);
    reset = 1'b0;
    tick(1);
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);
    rd(A_VADDR, 32'd0, 32'hFFFF_FFFF);

    // single output, unit samples, coef = index
    start_run(32'h1000, 9'd5, 1);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    wait_idle(200);
    rd(A_STAT, 32'h0000_0100, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'd0, 32'hFFFF_FFFF);
    pop_n(1);
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);

    // full 32-output run with saturated operands and a start while busy
    mem_mode = 1; coef_mode = 1;
    start_run($urandom & 32'hFFFF_FFFC, 9'($urandom_range(511)), 32);
    rd(A_CTRL, 32'h0000_1F00, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h0000_0001);
    wait_idle(2000);
    rd(A_CTRL, 32'd0, 32'hFFFF_FFFF);
    rd(A_STAT, 32'h0001_2000, 32'hFFFF_FFFF);
    pop_n(32);
    rd(A_RES, 32'd0, 32'hFFFF_FFFF);
    rd(A_STAT, 32'h0003_0000, 32'hFFFF_FFFF);
    wr(A_STAT, 32'h0007_0000);
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);

    // backpressure: fill the FIFO, then a second run must stall in PUSH
    mem_mode = 2; coef_mode = 2;
    start_run($urandom & 32'hFFFF_FFFC, 9'($urandom_range(511)), 32);
    wait_idle(2000);
    start_run($urandom & 32'hFFFF_FFFC, 9'($urandom_range(511)), 4);
    tick(150);
    chk("stall_busy", 32'(o_busy), 32'd1);
    chk("stall_no_cmd", 32'(cyc - last_cmd_cyc > 100), 32'd1);
    rd(A_STAT, 32'h0000_2001, 32'h0007_3F01);
    pop_n(32);
    wait_idle(1000);
    pop_n(4);
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);

    // memory stalls: random ready and latency must not change results
    rdy_pct = 70; lat_min = 1; lat_max = 5;
    for (int r = 0; r < 2; r++) begin
      cnt = $urandom_range(32, 1);
      start_run($urandom & 32'hFFFF_FFFC, 9'($urandom_range(511)), cnt);
      wait_idle(6000);
      pop_n(cnt);
    end
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);

    // reset after the third tap is issued, with responses still in flight
    rdy_pct = 100; lat_min = 5; lat_max = 5;
    base = cmd_cnt;
    start_run(32'h0002_0000, 9'd300, 4);
    n = 0;
    while (cmd_cnt < base + 3 && n < 200) begin tick(1); n++; end
    if (cmd_cnt < base + 3) begin
      checks++; failures++;
      $display("FAIL tap_wait_timeout: got %0d taps expected 3", cmd_cnt - base);
    end
    reset = 1'b1;
    exp_addr_q.delete(); exp_idx_q.delete(); res_q.delete();
    tick(1);
    reset = 1'b0;
    chk("mid_reset_busy", 32'(o_busy), 32'd0);
    tick(10);
    rd(A_STAT, 32'h0004_0000, 32'hFFFF_FFFF);
    wr(A_STAT, 32'h0007_0000);
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);
    lat_min = 1; lat_max = 1;
    start_run(32'h0000_4000, 9'd510, 3);
    wait_idle(500);
    pop_n(3);
    rd(A_STAT, 32'd0, 32'hFFFF_FFFF);

    n = 0;
    while (sb_q.size() > 0 && n < 20) begin tick(1); n++; end
    if (sb_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL rsp_missing: got %0d responses outstanding expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
